// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus: memory instruction port, redirect request and the
// valid/ready stream towards decode, bundled so the fetch unit and its
// environment see one typed connection.
interface fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // Memory instruction port (fixed one-cycle read latency)
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_word;

  // Redirect request from execute (branch/jump)
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  // Instruction stream towards decode
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;

  // Fetch-unit side
  modport master (
    output fetch_addr,
    input  fetch_word,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  // Environment side: memory, redirect source and decode
  modport slave (
    input  fetch_addr,
    output fetch_word,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator. Presents the PC to the memory instruction
// port, captures the returned word one cycle later and buffers {word, pc}
// pairs in a small prefetch FIFO that decode drains over valid/ready.
// Issue is credit based: an address is only issued when the FIFO is
// guaranteed to have room for its word, counting the request already in
// flight and any pop happening this cycle. Redirect flushes everything in
// flight and buffered; reset additionally clears the FIFO storage.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   occ_t;

  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  localparam occ_t DEPTH_OCC = occ_t'(DEPTH);

  // Fetch-side state
  logic [ADDR_W-1:0] r_pc;
  logic              r_req_v;
  logic [ADDR_W-1:0] r_req_pc;

  // Prefetch FIFO
  entry_t            r_fifo [DEPTH];
  ptr_t              r_rd_ptr;
  ptr_t              r_wr_ptr;
  cnt_t              r_count;

  // Per-cycle decisions
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  occ_t              w_occupancy;
  entry_t            w_head;

  // Circular pointer advance that also works for non-power-of-two depths
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Handshake, capture and issue-credit decisions for this cycle
  // NOTE: every signal is assigned on every path through the block, so no
  // latch can be inferred.
  always_comb begin
    w_pop       = (r_count != '0) && bus.instr_ready;
    w_push      = r_req_v && !bus.redirect;
    // Entries the FIFO will have to hold once the in-flight word lands and
    // the current head (if popped) has left. pop implies count >= 1, so the
    // subtraction cannot underflow.
    w_occupancy = {1'b0, r_count}
                + {{CNT_W{1'b0}}, r_req_v}
                - {{CNT_W{1'b0}}, w_pop};
    w_issue     = !bus.redirect && (w_occupancy < DEPTH_OCC);
  end

  // PC and in-flight request tracking; reset beats redirect beats issue
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_req_v  <= 1'b0;
      r_req_pc <= '0;
    end else if (bus.redirect) begin
      // The word returning this cycle belongs to the old path: drop it.
      r_pc     <= bus.redirect_pc;
      r_req_v  <= 1'b0;
    end else if (w_issue) begin
      r_req_v  <= 1'b1;
      r_req_pc <= r_pc;
      r_pc     <= r_pc + ADDR_W'(1);  // wraps modulo 2^ADDR_W
    end else begin
      r_req_v  <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue without
  // touching storage, the contents are simply unreachable afterwards
  always_ff @(posedge clk) begin
    if (reset || bus.redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_t'(1);
        2'b01:   r_count <= r_count - cnt_t'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: written at the tail on capture
  // NOTE: the storage array is reset explicitly because instr/instr_pc must
  // read as zero after reset; a plain RAM without reset would not give that.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo[r_wr_ptr] <= '{word: bus.fetch_word, pc: r_req_pc};
    end
  end

  // Outputs come straight from registers or the FIFO head
  assign w_head          = r_fifo[r_rd_ptr];
  assign bus.fetch_addr  = r_pc;
  assign bus.instr_valid = (r_count != '0);
  assign bus.instr       = w_head.word;
  assign bus.instr_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural memory answers every
// address one cycle later with a word derived from the address. The
// reference model is the architectural view of the stream: decode must see
// consecutive PCs from the last reset/redirect target, each paired with the
// memory word of that PC, with no drops or duplicates. Directed scenarios
// additionally pin down latency, stall and flush timing.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          ADDR_W   = 16;
  localparam int          DATA_W   = 16;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic clk = 1'b0;
  logic reset;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;
  logic [15:0] exp_pc = RESET_PC;

  fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory contents as a function of address (mem[0] is non-zero)
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a * 16'h9E37 + 16'h1234;
  endfunction

  // Memory instruction port: word for the address of cycle N appears in N+1
  always @(posedge clk) bus.fetch_word <= mem_word(bus.fetch_addr);

  // Reference model of the decode-side stream, evaluated mid-cycle
  task automatic model_step();
    if (reset) begin
      exp_pc = RESET_PC;
    end else begin
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
        n_tests++;
        n_pops++;
        if (bus.instr_pc !== exp_pc || bus.instr !== mem_word(exp_pc)) begin
          n_fail++;
          $display("FAIL stream_order: got pc=%h instr=%h, want pc=%h instr=%h",
                   bus.instr_pc, bus.instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 16'd1;
      end
      if (bus.redirect) exp_pc = bus.redirect_pc;
    end
  endtask

  // One clock: model at the falling edge, return 1 ns after the rising edge
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset; returns at the start of cycle 0
  task automatic do_reset();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;
    cycle();
    cycle();
    n_tests++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    n_tests++; if (bus.instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", bus.instr); end
    n_tests++; if (bus.instr_pc !== 16'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0000", bus.instr_pc); end
    n_tests++; if (bus.fetch_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_fetch_addr: got %h want %h", bus.fetch_addr, RESET_PC); end
    reset = 1'b0;
    // Stream: address c in cycle c, instruction c-2 from cycle 2 onwards
    for (int c = 0; c < 8; c++) begin
      n_tests++;
      if (bus.fetch_addr !== 16'(c)) begin
        n_fail++; $display("FAIL stream_addr c=%0d: got %h want %h", c, bus.fetch_addr, 16'(c));
      end
      n_tests++;
      if (bus.instr_valid !== (c >= 2)) begin
        n_fail++; $display("FAIL stream_valid c=%0d: got %b want %b", c, bus.instr_valid, (c >= 2));
      end
      if (c >= 2) begin
        n_tests++;
        if (bus.instr_pc !== 16'(c - 2) || bus.instr !== mem_word(16'(c - 2))) begin
          n_fail++; $display("FAIL stream_head c=%0d: got pc=%h instr=%h want pc=%h instr=%h",
                             c, bus.instr_pc, bus.instr, 16'(c - 2), mem_word(16'(c - 2)));
        end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cycle();
    cycle();
    // Cycle 2: decode stalls. The FIFO ends up holding pc 0 and pc 1; the
    // request for pc 1 is already in flight, so address 2 is never issued.
    bus.instr_ready = 1'b0;
    for (int c = 2; c < 7; c++) begin
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0 || bus.instr !== mem_word(16'h0)) begin
        n_fail++; $display("FAIL stall_head c=%0d: got v=%b pc=%h want v=1 pc=0000", c, bus.instr_valid, bus.instr_pc);
      end
      n_tests++;
      if (bus.fetch_addr !== 16'h2) begin
        n_fail++; $display("FAIL stall_addr c=%0d: got %h want 0002", c, bus.fetch_addr);
      end
      cycle();
    end
    // Release: the pop credit restarts issue at once, no bubble appears
    bus.instr_ready = 1'b1;
    for (int c = 7; c < 13; c++) begin
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'(c - 7)) begin
        n_fail++; $display("FAIL release_seq c=%0d: got v=%b pc=%h want v=1 pc=%h", c, bus.instr_valid, bus.instr_pc, 16'(c - 7));
      end
      cycle();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) cycle();
    // Cycle R=4: head pc 2 is popped while the redirect is taken
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h2) begin
      n_fail++; $display("FAIL redir_pop: got v=%b pc=%h want v=1 pc=0002", bus.instr_valid, bus.instr_pc);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    cycle();
    bus.redirect = 1'b0;
    n_tests++;
    if (bus.instr_valid !== 1'b0 || bus.fetch_addr !== 16'h0040) begin
      n_fail++; $display("FAIL redir_r1: got v=%b addr=%h want v=0 addr=0040", bus.instr_valid, bus.fetch_addr);
    end
    cycle();
    n_tests++;
    if (bus.instr_valid !== 1'b0 || bus.fetch_addr !== 16'h0041) begin
      n_fail++; $display("FAIL redir_r2: got v=%b addr=%h want v=0 addr=0041", bus.instr_valid, bus.fetch_addr);
    end
    cycle();
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0040 || bus.instr !== mem_word(16'h0040)) begin
      n_fail++; $display("FAIL redir_r3: got v=%b pc=%h instr=%h want v=1 pc=0040 instr=%h",
                         bus.instr_valid, bus.instr_pc, bus.instr, mem_word(16'h0040));
    end
    repeat (4) cycle();
  endtask

  task automatic test_redirect_full();
    do_reset();
    cycle();
    cycle();
    bus.instr_ready = 1'b0;
    repeat (3) cycle();
    // FIFO is full with pc 0 and pc 1; redirect with no pop
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0) begin
      n_fail++; $display("FAIL full_before: got v=%b pc=%h want v=1 pc=0000", bus.instr_valid, bus.instr_pc);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    cycle();
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    n_tests++;
    if (bus.instr_valid !== 1'b0 || bus.fetch_addr !== 16'h0100) begin
      n_fail++; $display("FAIL full_flush: got v=%b addr=%h want v=0 addr=0100", bus.instr_valid, bus.fetch_addr);
    end
    cycle();
    n_tests++;
    if (bus.instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_r2: got v=%b want 0", bus.instr_valid);
    end
    cycle();
    n_tests++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0100) begin
      n_fail++; $display("FAIL full_r3: got v=%b pc=%h want v=1 pc=0100", bus.instr_valid, bus.instr_pc);
    end
    repeat (4) cycle();
  endtask

  task automatic test_wrap();
    logic [15:0] want;
    do_reset();
    repeat (3) cycle();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    cycle();
    bus.redirect = 1'b0;
    cycle();
    cycle();
    for (int k = 0; k < 4; k++) begin
      want = 16'hFFFE + 16'(k);
      n_tests++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== want) begin
        n_fail++; $display("FAIL wrap k=%0d: got v=%b pc=%h want v=1 pc=%h", k, bus.instr_valid, bus.instr_pc, want);
      end
      cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle();
    cycle();
    // Cycle 2 with decode stalled: one entry buffered, one request in flight
    bus.instr_ready = 1'b0;
    n_tests++;
    if (bus.instr_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_before: got v=%b want 1", bus.instr_valid);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus.instr_ready = 1'b1;
    n_tests++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0 || bus.instr_pc !== 16'h0) begin
      n_fail++; $display("FAIL mid_clear: got v=%b instr=%h pc=%h want v=0 instr=0000 pc=0000",
                         bus.instr_valid, bus.instr, bus.instr_pc);
    end
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (bus.instr_valid !== (c == 2)) begin
        n_fail++; $display("FAIL mid_restart c=%0d: got v=%b want %b", c, bus.instr_valid, (c == 2));
      end
      if (c == 0) begin
        n_tests++;
        if (bus.fetch_addr !== RESET_PC) begin
          n_fail++; $display("FAIL mid_addr: got %h want %h", bus.fetch_addr, RESET_PC);
        end
      end
      cycle();
    end
    n_tests++;
    if (bus.instr_pc !== RESET_PC + 16'd1) begin
      n_fail++; $display("FAIL mid_stream: got pc=%h want %h", bus.instr_pc, RESET_PC + 16'd1);
    end
    cycle();
  endtask

  task automatic test_random();
    int pops_start;
    do_reset();
    pops_start = n_pops;
    for (int i = 0; i < 600; i++) begin
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.redirect    = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = 16'($urandom);
      reset           = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset           = 1'b0;
    bus.redirect    = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (6) cycle();
    n_tests++;
    if (n_pops - pops_start < 150) begin
      n_fail++; $display("FAIL random_progress: got %0d pops want at least 150", n_pops - pops_start);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
